// File: rtl/alu_seq_if.sv
// Command, ALU and memory-bus bundle for the execute sequencer.
// master = sequencer side, slave = decoder/ALU/memory environment.
interface alu_seq_if #(parameter int AW = 16);
  logic          start;
  logic [1:0]    cmd_mode;
  logic [3:0]    cmd_alu;
  logic [2:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    reg_in;
  logic [7:0]    p_in;
  logic [7:0]    alu_a;
  logic [7:0]    alu_b;
  logic [3:0]    alu_mode;
  logic [2:0]    alu_op;
  logic [7:0]    alu_p;
  logic [7:0]    alu_r;
  logic [7:0]    alu_f;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din;
  logic          mem_ready;
  logic          busy;
  logic          done;
  logic [7:0]    reg_out;
  logic          reg_we;
  logic [7:0]    p_out;
  logic          p_we;

  modport master (
    input  start, cmd_mode, cmd_alu, cmd_op, cmd_addr, reg_in, p_in,
    input  alu_r, alu_f, mem_din, mem_ready,
    output alu_a, alu_b, alu_mode, alu_op, alu_p,
    output mem_addr, mem_rd, mem_wr, mem_dout,
    output busy, done, reg_out, reg_we, p_out, p_we
  );

  modport slave (
    output start, cmd_mode, cmd_alu, cmd_op, cmd_addr, reg_in, p_in,
    output alu_r, alu_f, mem_din, mem_ready,
    input  alu_a, alu_b, alu_mode, alu_op, alu_p,
    input  mem_addr, mem_rd, mem_wr, mem_dout,
    input  busy, done, reg_out, reg_we, p_out, p_we
  );
endinterface

// File: rtl/alu_seq.sv
// Multi-cycle execute sequencer: operand fetch, shared-ALU drive and
// register/flag/memory commit with 6502 RMW bus ordering (read, dummy
// write of the original value, final write). One command in flight.
module alu_seq #(
  parameter int AW = 16
) (
  input logic       clk,
  input logic       rst_n,
  alu_seq_if.master io
);
  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_EXEC, S_DWR, S_WRITE, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    mode_q;
  logic [3:0]    alu_q;
  logic [2:0]    op_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    reg_q, p_q, opnd_q, res_q, flg_q;
  logic          accept;
  logic          no_reg_wr;

  assign accept    = (state_q == S_IDLE) && io.start;
  // Compare, bit test, flag ops and store only update flags (or nothing).
  assign no_reg_wr = (alu_q == 4'b0110) || (alu_q == 4'b1101) ||
                     (alu_q == 4'b1100) || (alu_q == 4'b0100);

  // State and command/operand/result latches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      alu_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      reg_q   <= '0;
      p_q     <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        mode_q <= io.cmd_mode;
        alu_q  <= io.cmd_alu;
        op_q   <= io.cmd_op;
        addr_q <= io.cmd_addr;
        reg_q  <= io.reg_in;
        p_q    <= io.p_in;
        // Register-mode operand is the register itself; memory modes
        // overwrite this when the read completes.
        opnd_q <= io.reg_in;
      end
      if (state_q == S_READ && io.mem_ready) opnd_q <= io.mem_din;
      if (state_q == S_EXEC) begin
        res_q <= io.alu_r;
        flg_q <= io.alu_f;
      end
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (io.start) begin
          case (io.cmd_mode)
            2'd0:    state_d = S_EXEC;
            2'd3:    state_d = S_WRITE;
            default: state_d = S_READ;
          endcase
        end
      S_READ:  if (io.mem_ready) state_d = S_EXEC;
      S_EXEC:  state_d = (mode_q == 2'd2) ? S_DWR : S_DONE;
      S_DWR:   if (io.mem_ready) state_d = S_WRITE;
      S_WRITE: if (io.mem_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus and commit outputs decoded from the current state.
  always_comb begin
    io.mem_rd   = 1'b0;
    io.mem_wr   = 1'b0;
    io.mem_addr = '0;
    io.mem_dout = '0;
    io.done     = 1'b0;
    io.reg_we   = 1'b0;
    io.reg_out  = '0;
    io.p_we     = 1'b0;
    io.p_out    = '0;
    case (state_q)
      S_READ: begin
        io.mem_rd   = 1'b1;
        io.mem_addr = addr_q;
      end
      S_DWR: begin
        io.mem_wr   = 1'b1;
        io.mem_addr = addr_q;
        io.mem_dout = opnd_q;
      end
      S_WRITE: begin
        io.mem_wr   = 1'b1;
        io.mem_addr = addr_q;
        io.mem_dout = (mode_q == 2'd2) ? res_q : reg_q;
      end
      S_DONE: begin
        io.done = 1'b1;
        if (mode_q != 2'd3) begin
          io.p_we  = 1'b1;
          io.p_out = flg_q;
        end
        if (!mode_q[1] && !no_reg_wr) begin
          io.reg_we  = 1'b1;
          io.reg_out = res_q;
        end
      end
      default: ;
    endcase
  end

  assign io.busy     = (state_q != S_IDLE);
  assign io.alu_a    = reg_q;
  assign io.alu_b    = opnd_q;
  assign io.alu_mode = alu_q;
  assign io.alu_op   = op_q;
  assign io.alu_p    = p_q;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU and byte memory as the
// environment, per-command expectations of bus traffic and commit outputs.
module tb_alu_seq;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.AW(AW)) bus();
  alu_seq #(.AW(AW)) dut (.clk(clk), .rst_n(rst_n), .io(bus));

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  mem [0:255];
  logic [24:0] log_q [$];
  int rd_cyc   = 0;
  int excl_err = 0;
  int rdy_mode = 0;
  int wc       = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Flags: N=7 V=6 Z=1 C=0; returns {result, flags}.
  function automatic logic [15:0] alu_fn(input logic [3:0] m, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] p);
    logic [8:0] s;
    logic [7:0] r, f;
    f = p; r = '0;
    case (m)
      4'b0011: begin
        s = 9'(a) + 9'(b) + 9'(p[0]);
        r = s[7:0]; f[0] = s[8];
        f[6] = (a[7] == b[7]) && (r[7] != a[7]);
      end
      4'b1111: r = 8'(b + 8'd1);
      4'b1000: begin r = {b[6:0], 1'b0}; f[0] = b[7]; end
      4'b0110: begin s = 9'(a) - 9'(b); r = s[7:0]; f[0] = (a >= b); end
      4'b1101: begin
        r = a & b; f[7] = b[7]; f[6] = b[6]; f[1] = (r == 8'd0);
        return {r, f};
      end
      4'b1100: return {8'h00, p ^ 8'h01};
      4'b0100: r = a;
      default: r = a ^ b ^ {4'h0, m};
    endcase
    f[7] = r[7]; f[1] = (r == 8'd0);
    return {r, f};
  endfunction

  always_comb {bus.alu_r, bus.alu_f} = alu_fn(bus.alu_mode, bus.alu_a, bus.alu_b, bus.alu_p);
  assign bus.mem_din = mem[bus.mem_addr[7:0]];

  // Bus monitor: completed accesses, rd/wr overlap, read-hold cycles.
  always @(posedge clk) begin
    if (bus.mem_rd && bus.mem_wr) excl_err++;
    if (bus.mem_rd) rd_cyc++;
    if (bus.mem_rd && bus.mem_ready) log_q.push_back({1'b0, bus.mem_addr, bus.mem_din});
    if (bus.mem_wr && bus.mem_ready) begin
      log_q.push_back({1'b1, bus.mem_addr, bus.mem_dout});
      mem[bus.mem_addr[7:0]] = bus.mem_dout;
    end
  end

  // Ready generator: 0 = always ready, 1 = random, 2 = three wait cycles per access.
  always @(negedge clk) begin
    if (!(bus.mem_rd || bus.mem_wr)) begin
      wc = 0;
      bus.mem_ready = (rdy_mode == 0);
    end else if (rdy_mode == 0) bus.mem_ready = 1'b1;
    else if (rdy_mode == 1) bus.mem_ready = ($urandom_range(0, 2) != 0);
    else if (wc < 3) begin bus.mem_ready = 1'b0; wc++; end
    else begin bus.mem_ready = 1'b1; wc = 0; end
  end

  task automatic run_cmd(input logic [1:0] md, input logic [3:0] al, input logic [2:0] op,
                         input logic [15:0] ad, input logic [7:0] rg, input logic [7:0] p,
                         input bit chk_lat, output int lat,
                         output logic [7:0] rout, output logic [7:0] pout);
    logic [7:0]  b, er, ef;
    logic [15:0] rf;
    logic [24:0] elog [$];
    bit erwe, epwe, seen;
    b  = (md == 2'd0 || md == 2'd3) ? rg : mem[ad[7:0]];
    rf = alu_fn(al, rg, b, p);
    er = rf[15:8]; ef = rf[7:0];
    if (md == 2'd1 || md == 2'd2) elog.push_back({1'b0, ad, b});
    if (md == 2'd2) begin
      elog.push_back({1'b1, ad, b});
      elog.push_back({1'b1, ad, er});
    end
    if (md == 2'd3) elog.push_back({1'b1, ad, rg});
    erwe = (md < 2'd2) && !(al inside {4'b0110, 4'b1101, 4'b1100, 4'b0100});
    epwe = (md != 2'd3);

    @(negedge clk);
    chk("idle_busy", {31'd0, bus.busy}, 0);
    chk("idle_done", {31'd0, bus.done}, 0);
    log_q.delete();
    bus.start = 1'b1; bus.cmd_mode = md; bus.cmd_alu = al; bus.cmd_op = op;
    bus.cmd_addr = ad; bus.reg_in = rg; bus.p_in = p;
    lat = 0; seen = 0; rout = '0; pout = '0;
    while (!seen && lat < 400) begin
      @(negedge clk);
      lat++;
      // Garbage on the command inputs while busy must be ignored.
      bus.start = (lat == 1);
      bus.cmd_mode = 2'($urandom); bus.cmd_alu = 4'($urandom);
      bus.cmd_op = 3'($urandom); bus.cmd_addr = 16'($urandom);
      bus.reg_in = 8'($urandom); bus.p_in = 8'($urandom);
      if (bus.done) begin
        seen = 1;
        rout = bus.reg_out; pout = bus.p_out;
        chk("reg_we", {31'd0, bus.reg_we}, {31'd0, erwe});
        chk("p_we", {31'd0, bus.p_we}, {31'd0, epwe});
        if (erwe) chk("reg_out", {24'd0, bus.reg_out}, {24'd0, er});
        if (epwe) chk("p_out", {24'd0, bus.p_out}, {24'd0, ef});
        chk("done_busy", {31'd0, bus.busy}, 1);
      end
    end
    bus.start = 1'b0;
    chk("done_seen", {31'd0, seen}, 1);
    if (chk_lat) chk("latency", lat, (md == 2'd1) ? 3 : 2);
    chk("bus_len", log_q.size(), elog.size());
    for (int i = 0; i < elog.size(); i++)
      if (i < log_q.size()) chk("bus_seq", {7'd0, log_q[i]}, {7'd0, elog[i]});
  endtask

  initial begin
    int lat;
    logic [7:0] ro, po;
    bit got_wr;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.cmd_mode = '0; bus.cmd_alu = '0; bus.cmd_op = '0;
    bus.cmd_addr = '0; bus.reg_in = '0; bus.p_in = '0; bus.mem_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_bus", {29'd0, bus.mem_rd, bus.mem_wr, 1'b0}, 0);
    chk("rst_addr", {16'd0, bus.mem_addr}, 0);
    chk("rst_we", {30'd0, bus.reg_we, bus.p_we}, 0);
    chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_p, bus.alu_mode, 1'b0, bus.alu_op}, 0);
    rst_n = 1'b1;

    // INC in register mode.
    run_cmd(2'd0, 4'b1111, 3'd7, 16'h0000, 8'hFF, 8'h00, 1, lat, ro, po);
    chk("inc_r", {24'd0, ro}, 32'h00);
    chk("inc_p", {24'd0, po}, 32'h02);

    // ADC load-op with three wait cycles.
    rdy_mode = 2; mem[8'h10] = 8'h50; rd_cyc = 0;
    run_cmd(2'd1, 4'b0011, 3'd3, 16'h0010, 8'h50, 8'h00, 0, lat, ro, po);
    chk("rd_hold", rd_cyc, 4);
    chk("adc_r", {24'd0, ro}, 32'hA0);
    chk("adc_p", {24'd0, po}, 32'hC0);

    // ASL read-modify-write.
    rdy_mode = 0; mem[8'h00] = 8'h81;
    run_cmd(2'd2, 4'b1000, 3'd0, 16'h0200, 8'h33, 8'h00, 0, lat, ro, po);
    chk("asl_p", {24'd0, po}, 32'h01);
    chk("asl_mem", {24'd0, mem[8'h00]}, 32'h02);

    // CMP equal.
    mem[8'h30] = 8'h10;
    run_cmd(2'd1, 4'b0110, 3'd6, 16'h0030, 8'h10, 8'h00, 1, lat, ro, po);
    chk("cmp_p", {24'd0, po}, 32'h03);

    // Store.
    run_cmd(2'd3, 4'b0100, 3'd4, 16'h1234, 8'h5A, 8'h00, 1, lat, ro, po);
    chk("sta_mem", {24'd0, mem[8'h34]}, 32'h5A);

    // Reset while the RMW dummy write is stalled.
    rdy_mode = 2; mem[8'h44] = 8'h81;
    @(negedge clk);
    bus.start = 1'b1; bus.cmd_mode = 2'd2; bus.cmd_alu = 4'b1000; bus.cmd_addr = 16'h0344;
    bus.reg_in = 8'h00; bus.p_in = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    got_wr = 0;
    for (int i = 0; i < 50 && !got_wr; i++) begin
      if (bus.mem_wr) got_wr = 1;
      else @(negedge clk);
    end
    chk("dwr_reached", {31'd0, got_wr}, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_drop", {31'd0, bus.mem_wr}, 0);
    chk("rst_busy_drop", {31'd0, bus.busy}, 0);
    log_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_no_write", log_q.size(), 0);
    chk("rst_mem_keep", {24'd0, mem[8'h44]}, 32'h81);
    rdy_mode = 0;
    run_cmd(2'd1, 4'b0011, 3'd3, 16'h0044, 8'h01, 8'h01, 1, lat, ro, po);

    // Randomized commands, back-to-back, mixed bus timing.
    for (int n = 0; n < 80; n++) begin
      logic [1:0] md;
      md = 2'($urandom_range(0, 3));
      rdy_mode = $urandom_range(0, 1);
      run_cmd(md, 4'($urandom), 3'($urandom), 16'($urandom), 8'($urandom), 8'($urandom),
              (rdy_mode == 0) && (md != 2'd2), lat, ro, po);
    end

    chk("rd_wr_excl", excl_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
